// File: rtl/restoring_div4_pkg.sv
// rtl/restoring_div4_pkg.sv - shared width, iteration count and FSM encoding for the restoring divider
package restoring_div4_pkg;

  // Operand and result width; the datapath is built for 4 bits only
  localparam int DIV_WIDTH = 4;

  // One restoring iteration per quotient bit
  localparam int ITERATIONS = 4;

  // Value of the iteration counter during the final iteration
  localparam logic [1:0] LAST_COUNT = 2'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/restoring_div4_adder_sub.sv
// rtl/restoring_div4_adder_sub.sv - 4-bit adder/subtractor used as the trial subtractor
module restoring_div4_adder_sub
  import restoring_div4_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  input  logic                 sub,
  output logic [DIV_WIDTH-1:0] sum,
  output logic                 cout
);

  logic [DIV_WIDTH-1:0] b_eff;
  logic [DIV_WIDTH:0]   total;

  // sub=1 computes a + ~b + 1, so cout=1 means the subtraction did not borrow
  always_comb begin
    b_eff = b ^ {DIV_WIDTH{sub}};
    total = {1'b0, a} + {1'b0, b_eff} + {{DIV_WIDTH{1'b0}}, sub};
    sum   = total[DIV_WIDTH-1:0];
    cout  = total[DIV_WIDTH];
  end

endmodule

// File: rtl/restoring_div4.sv
// rtl/restoring_div4.sv - multi-cycle 4-bit unsigned restoring divider, one quotient bit per clock
module restoring_div4
  import restoring_div4_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t state;
  div_state_t state_next;

  logic [WIDTH-1:0] dvd;       // captured dividend, shifted left as bits are consumed
  logic [WIDTH-1:0] dvs;       // captured divisor
  logic [WIDTH-1:0] rem_acc;   // partial remainder, always < dvs between iterations
  logic [WIDTH-2:0] quo_acc;   // quotient bits settled so far
  logic [1:0]       count;
  logic             zero_div;  // captured divisor was zero

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic             take;
  logic [WIDTH-1:0] next_rem;
  logic             last_iter;

  // The 5-bit trial value can exceed 15, but the true difference is below dvs,
  // so the low 4 bits of T[3:0]-dvs are the exact new remainder in either case
  restoring_div4_adder_sub u_adder_sub (
    .a    (trial[WIDTH-1:0]),
    .b    (dvs),
    .sub  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  // Trial step: bring down the next dividend bit and decide whether the divisor fits
  always_comb begin
    trial     = {rem_acc, dvd[WIDTH-1]};
    take      = trial[WIDTH] | no_borrow;
    next_rem  = take ? diff : trial[WIDTH-1:0];
    last_iter = (count == LAST_COUNT);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a zero divisor spends a single cycle in CALC to load its fixed result
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (zero_div || last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: operand capture, iterations, and the single edge that loads the visible results
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd         <= '0;
      dvs         <= '0;
      rem_acc     <= '0;
      quo_acc     <= '0;
      count       <= '0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd      <= dividend;
            dvs      <= divisor;
            rem_acc  <= '0;
            quo_acc  <= '0;
            count    <= '0;
            zero_div <= (divisor == '0);
            if (divisor != '0) div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= dvd;
            div_by_zero <= 1'b1;
          end else begin
            rem_acc <= next_rem;
            quo_acc <= {quo_acc[WIDTH-3:0], take};
            dvd     <= {dvd[WIDTH-2:0], 1'b0};
            count   <= count + 2'd1;
            if (last_iter) begin
              quotient  <= {quo_acc, take};
              remainder <= next_rem;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div4.sv
// tb/tb_restoring_div4.sv - directed and exhaustive self-checking bench for restoring_div4
module tb_restoring_div4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs [10];

  restoring_div4 #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one division, measure edges from acceptance to done, check results and pulse width
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                         input logic [3:0] er, input logic ez, input int elat, input bit full);
    int lat;
    step();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (done) begin
        lat = k;
        break;
      end
    end
    if (full) begin
      check($sformatf("latency %0d/%0d", a, b), lat, elat);
      check($sformatf("quotient %0d/%0d", a, b), {28'd0, quotient}, {28'd0, eq});
      check($sformatf("remainder %0d/%0d", a, b), {28'd0, remainder}, {28'd0, er});
      check($sformatf("div_by_zero %0d/%0d", a, b), {31'd0, div_by_zero}, {31'd0, ez});
      check($sformatf("busy_at_done %0d/%0d", a, b), {31'd0, busy}, 32'd1);
    end else begin
      check($sformatf("sweep %0d/%0d {lat,q,r,z}", a, b),
            {lat[15:0], 3'd0, quotient, remainder, div_by_zero},
            {elat[15:0], 3'd0, eq, er, ez});
    end
    step();
    check($sformatf("done_pulse_end %0d/%0d {done,busy}", a, b), {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;

    vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1,  1'b0, 4};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0, 4};
    vecs[2] = '{4'd7,  4'd9,  4'd0,  4'd7,  1'b0, 4};
    vecs[3] = '{4'd9,  4'd0,  4'hF,  4'd9,  1'b1, 1};
    vecs[4] = '{4'd8,  4'd2,  4'd4,  4'd0,  1'b0, 4};
    vecs[5] = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0, 4};
    vecs[6] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0, 4};
    vecs[7] = '{4'd0,  4'd0,  4'hF,  4'd0,  1'b1, 1};
    vecs[8] = '{4'd11, 4'd8,  4'd1,  4'd3,  1'b0, 4};
    vecs[9] = '{4'd14, 4'd3,  4'd4,  4'd2,  1'b0, 4};

    step();
    step();
    check("reset {busy,done,q,r,z}", {21'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat, 1'b1);

    // Start and new operands held during CALC and DONE of 13/4 must be ignored
    step();
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    step();
    dividend = 4'd6;
    divisor  = 4'd3;
    step();
    check("held_q_during_calc", {28'd0, quotient}, 32'd4);
    check("held_r_during_calc", {28'd0, remainder}, 32'd2);
    pulses = 0;
    for (int k = 0; k < 10 && !done; k++) step();
    if (done) pulses++;
    start = 1'b0;
    check("busy_ignore quotient", {28'd0, quotient}, 32'd3);
    check("busy_ignore remainder", {28'd0, remainder}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      if (done) pulses++;
    end
    check("busy_ignore done_pulses", pulses, 1);
    check("busy_ignore idle_after", {31'd0, busy}, 32'd0);

    // Reset at edge N+2 of 13/4 aborts it with no done afterwards
    step();
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("abort {busy,done,q,r,z}", {21'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done || busy) pulses++;
    end
    check("abort no_done_or_busy", pulses, 0);
    run_div(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 4, 1'b1);

    // Every operand pair against an arithmetic reference
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b != 0)
          run_div(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 4, 1'b0);
        else
          run_div(4'(a), 4'(b), 4'hF, 4'(a), 1'b1, 1, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
